// File: rtl/l2_ahb_pkg.sv
// l2_ahb_pkg -- shared AHB-Lite encodings and types for the L2 receive slave.
//   HTRANS active encodings, the word HSIZE code, HRESP codes, the slave
//   data-phase state enum and the registered address-phase record.
package l2_ahb_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BIT32   = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  // Address-phase fields captured at acceptance, consumed in the data phase.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
  } ahb_aph_t;

endpackage

// File: rtl/l2_sync_fifo.sv
// l2_sync_fifo -- single-clock FIFO, DEPTH x W, with occupancy outputs.
//   clk, rst_n     : clock, async active-low reset
//   clr            : synchronous flush, wins over push/pop
//   push, din      : write (ignored while full)
//   pop            : read/advance (ignored while empty)
//   dout           : head entry, 0 while empty
//   level/full/empty : occupancy
module l2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = cnt;

endmodule

// File: rtl/l2_ahb_rx_slv.sv
// l2_ahb_rx_slv -- AHB-Lite responder feeding a receive FIFO.
//   Word writes to DATA_ADDR push hwdata into the FIFO (wait states while
//   full); word reads of STAT_ADDR return {level, full, empty}. Anything else
//   gets a two-cycle ERROR response.
//   clk, rst_n          : clock, async active-low reset
//   pin_l2_clr          : synchronous clear (FIFO flush, bus back to IDLE)
//   s_ahb_*             : AHB-Lite responder port (hburst ignored)
//   rx_rd_en / rx_dout  : FIFO pop / head entry
//   rx_empty/full/level : FIFO occupancy
// Build option: define L2_AHB_RX_SLV_WAITCNT_EN to add a 16-bit saturating
//   count of full-FIFO wait states, readable as a word at STAT_ADDR+4.
module l2_ahb_rx_slv
  import l2_ahb_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DATA_ADDR = 32'h8000_0000,
  parameter logic [31:0] STAT_ADDR = 32'h8000_0004
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pin_l2_clr,
  input  logic [1:0]             s_ahb_htrans,
  input  logic [2:0]             s_ahb_hsize,
  input  logic [2:0]             s_ahb_hburst,
  input  logic                   s_ahb_hwrite,
  input  logic [31:0]            s_ahb_haddr,
  input  logic [31:0]            s_ahb_hwdata,
  output logic [31:0]            s_ahb_hrdata,
  output logic                   s_ahb_hready,
  output logic [1:0]             s_ahb_hresp,
  input  logic                   rx_rd_en,
  output logic [31:0]            rx_dout,
  output logic                   rx_empty,
  output logic                   rx_full,
  output logic [$clog2(DEPTH):0] rx_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  ahb_state_e state, state_nxt;
  ahb_aph_t   d_aph;
  logic       aph_act, aph_legal, accept;
  logic       wr_phase, wr_wait, push;
  logic       hready;
  logic [1:0] hresp;

  // Burst type carries no meaning for a single-register target.
  logic unused_hburst;
  assign unused_hburst = ^s_ahb_hburst;

  assign aph_act = (s_ahb_htrans == HTRANS_NONSEQ) || (s_ahb_htrans == HTRANS_SEQ);

  always_comb begin
    aph_legal = 1'b0;
    if (s_ahb_hsize == HSIZE_BIT32) begin
      if ( s_ahb_hwrite && s_ahb_haddr == DATA_ADDR) aph_legal = 1'b1;
      if (!s_ahb_hwrite && s_ahb_haddr == STAT_ADDR) aph_legal = 1'b1;
`ifdef L2_AHB_RX_SLV_WAITCNT_EN
      if (!s_ahb_hwrite && s_ahb_haddr == STAT_ADDR + 32'd4) aph_legal = 1'b1;
`endif
    end
  end

  assign wr_phase = (state == ST_DATA) && d_aph.write;
  // Full-FIFO stall; a pop in this same cycle only frees the slot for the next.
  assign wr_wait  = wr_phase && rx_full;

  // hready gates acceptance of the overlapping address phase, so the
  // next state is chosen from it whenever the current data phase ends.
  always_comb begin
    hready    = 1'b1;
    hresp     = HRESP_OKAY;
    state_nxt = state;
    if (pin_l2_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_DATA: hready = ~wr_wait;
        ST_ERR1: begin
          hready    = 1'b0;
          hresp     = HRESP_ERROR;
          state_nxt = ST_ERR2;
        end
        ST_ERR2: hresp = HRESP_ERROR;
        default: ;
      endcase
      if (hready) begin
        if (!aph_act)       state_nxt = ST_IDLE;
        else if (aph_legal) state_nxt = ST_DATA;
        else                state_nxt = ST_ERR1;
      end
    end
  end

  assign accept = hready && aph_act && !pin_l2_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      d_aph <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        d_aph.write <= s_ahb_hwrite;
        d_aph.addr  <= s_ahb_haddr;
        d_aph.size  <= s_ahb_hsize;
      end
    end
  end

  assign push = wr_phase && !rx_full && !pin_l2_clr;

  l2_sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pin_l2_clr),
    .push  (push),
    .din   (s_ahb_hwdata),
    .pop   (rx_rd_en),
    .dout  (rx_dout),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef L2_AHB_RX_SLV_WAITCNT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              wait_cnt <= '0;
    else if (pin_l2_clr)                     wait_cnt <= '0;
    else if (wr_wait && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
  end
`endif

  logic stat_rd;
  assign stat_rd = (state == ST_DATA) && !d_aph.write && (d_aph.size == HSIZE_BIT32)
                   && !pin_l2_clr;

  always_comb begin
    s_ahb_hrdata = '0;
    if (stat_rd) begin
      if (d_aph.addr == STAT_ADDR) s_ahb_hrdata[LW+1:0] = {rx_level, rx_full, rx_empty};
`ifdef L2_AHB_RX_SLV_WAITCNT_EN
      else if (d_aph.addr == STAT_ADDR + 32'd4) s_ahb_hrdata[15:0] = wait_cnt;
`endif
    end
  end

  assign s_ahb_hready = hready;
  assign s_ahb_hresp  = hresp;

endmodule

// File: tb/tb_l2_ahb_rx_slv.sv
// tb_l2_ahb_rx_slv -- scoreboard bench for l2_ahb_rx_slv (DEPTH=8).
//   The driver queues the expected data-phase response (resp, rdata, wait
//   count) and expected pop data; a negedge monitor tracks AHB data phases
//   and FIFO pops and compares against the queue heads.
module tb_l2_ahb_rx_slv;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] DATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STAT_ADDR = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pin_l2_clr = 1'b0;
  logic [1:0]  s_ahb_htrans = 2'b00;
  logic [2:0]  s_ahb_hsize = 3'b010;
  logic [2:0]  s_ahb_hburst = 3'b000;
  logic        s_ahb_hwrite = 1'b0;
  logic [31:0] s_ahb_haddr = '0;
  logic [31:0] s_ahb_hwdata = '0;
  logic [31:0] s_ahb_hrdata;
  logic        s_ahb_hready;
  logic [1:0]  s_ahb_hresp;
  logic        rx_rd_en = 1'b0;
  logic [31:0] rx_dout;
  logic        rx_empty, rx_full;
  logic [3:0]  rx_level;

  always #5 clk = ~clk;

  l2_ahb_rx_slv #(.DEPTH(DEPTH), .DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .pin_l2_clr(pin_l2_clr),
    .s_ahb_htrans(s_ahb_htrans), .s_ahb_hsize(s_ahb_hsize), .s_ahb_hburst(s_ahb_hburst),
    .s_ahb_hwrite(s_ahb_hwrite), .s_ahb_haddr(s_ahb_haddr), .s_ahb_hwdata(s_ahb_hwdata),
    .s_ahb_hrdata(s_ahb_hrdata), .s_ahb_hready(s_ahb_hready), .s_ahb_hresp(s_ahb_hresp),
    .rx_rd_en(rx_rd_en), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_level(rx_level)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dout_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: data phase exists the cycle after an accepted NONSEQ/SEQ.
  logic in_dph = 1'b0;
  int   wcnt = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rx_rd_en && !rx_empty) begin
        if (dout_q.size() == 0) flag("unexpected_pop");
        else chk("rx_dout", rx_dout, dout_q.pop_front());
      end
      if (in_dph) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_dphase");
        end else if (pin_l2_clr) begin
          e = exp_q.pop_front();
          chk("clr_hready", {31'd0, s_ahb_hready}, 32'd1);
          wcnt = 0;
        end else if (!s_ahb_hready) begin
          e = exp_q[0];
          wcnt++;
          chk("wait_hresp", {30'd0, s_ahb_hresp}, {30'd0, e.resp});
        end else begin
          e = exp_q.pop_front();
          chk("hresp", {30'd0, s_ahb_hresp}, {30'd0, e.resp});
          chk("hrdata", s_ahb_hrdata, e.rdata);
          chk("waits", wcnt, e.waits);
          wcnt = 0;
        end
      end
      if (pin_l2_clr)        in_dph = 1'b0;
      else if (s_ahb_hready) in_dph = s_ahb_htrans[1];
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive an address phase until accepted, then its write data.
  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      input logic [1:0] resp, input logic [31:0] rdata, input int waits);
    exp_t e;
    bit   acc;
    int   n;
    e.resp = resp; e.rdata = rdata; e.waits = waits;
    exp_q.push_back(e);
    s_ahb_htrans = tr; s_ahb_hwrite = wr; s_ahb_haddr = addr; s_ahb_hsize = size;
    s_ahb_hburst = 3'b001;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_ahb_hready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) flag("accept_timeout");
    s_ahb_hwdata = wdata;
    s_ahb_htrans = 2'b00;
  endtask

  task automatic wr(input logic [31:0] d);
    xfer(2'b10, 1'b1, DATA_ADDR, 3'b010, d, 2'b00, 32'd0, 0);
  endtask

  task automatic pop(input logic [31:0] exp);
    dout_q.push_back(exp);
    rx_rd_en = 1'b1;
    step(1);
    rx_rd_en = 1'b0;
  endtask

  task automatic chk_stat(input string name, input logic [3:0] lvl, input logic full, input logic empty);
    chk({name, "_level"}, {28'd0, rx_level}, {28'd0, lvl});
    chk({name, "_full"},  {31'd0, rx_full},  {31'd0, full});
    chk({name, "_empty"}, {31'd0, rx_empty}, {31'd0, empty});
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_hready", {31'd0, s_ahb_hready}, 32'd1);
    chk("rst_hresp",  {30'd0, s_ahb_hresp},  32'd0);
    chk("rst_hrdata", s_ahb_hrdata, 32'd0);
    chk("rst_dout",   rx_dout, 32'd0);
    chk_stat("rst", 4'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step(2);

    // IDLE/BUSY toward DATA_ADDR are ignored with OKAY
    s_ahb_htrans = 2'b01; s_ahb_hwrite = 1'b1; s_ahb_haddr = DATA_ADDR; s_ahb_hsize = 3'b010;
    step(2);
    chk("busy_hresp", {30'd0, s_ahb_hresp}, 32'd0);
    s_ahb_htrans = 2'b00;
    step(1);
    chk_stat("busy", 4'd0, 1'b0, 1'b1);

    // Pop while empty is ignored
    rx_rd_en = 1'b1;
    step(1);
    rx_rd_en = 1'b0;
    chk_stat("pop_empty", 4'd0, 1'b0, 1'b1);

    // Four back-to-back word writes, mixed NONSEQ/SEQ
    wr(32'h11);
    xfer(2'b11, 1'b1, DATA_ADDR, 3'b010, 32'h22, 2'b00, 32'd0, 0);
    wr(32'h33);
    xfer(2'b11, 1'b1, DATA_ADDR, 3'b010, 32'h44, 2'b00, 32'd0, 0);
    step(2);
    chk_stat("four_wr", 4'd4, 1'b0, 1'b0);
    pop(32'h11); pop(32'h22); pop(32'h33); pop(32'h44);
    chk_stat("four_pop", 4'd0, 1'b0, 1'b1);

    // Illegal transfers: byte write, read of DATA_ADDR, write of STAT_ADDR
    xfer(2'b10, 1'b1, DATA_ADDR, 3'b000, 32'hAA, 2'b01, 32'd0, 1);
    step(3);
    chk_stat("byte_wr", 4'd0, 1'b0, 1'b1);
    xfer(2'b10, 1'b0, DATA_ADDR, 3'b010, 32'h0, 2'b01, 32'd0, 1);
    xfer(2'b10, 1'b1, STAT_ADDR, 3'b010, 32'hBB, 2'b01, 32'd0, 1);
    step(3);
    chk_stat("bad_addr", 4'd0, 1'b0, 1'b1);

    // DEPTH+1 writes: last one stalls until a pop, then lands next cycle
    for (int i = 0; i < DEPTH; i++) wr(32'h100 + i);
    xfer(2'b10, 1'b1, DATA_ADDR, 3'b010, 32'h108, 2'b00, 32'd0, 4);
    step(3);
    pop(32'h100);
    step(2);
    chk_stat("full_wr", 4'd8, 1'b1, 1'b0);

    // Clear during a full-FIFO wait discards the write
    xfer(2'b10, 1'b1, DATA_ADDR, 3'b010, 32'h200, 2'b00, 32'd0, 0);
    pin_l2_clr = 1'b1;
    step(1);
    pin_l2_clr = 1'b0;
    chk("clr_hready_after", {31'd0, s_ahb_hready}, 32'd1);
    chk("clr_hresp_after",  {30'd0, s_ahb_hresp},  32'd0);
    chk_stat("clr", 4'd0, 1'b0, 1'b1);
    step(2);
    chk_stat("clr_nopush", 4'd0, 1'b0, 1'b1);

    // Five full-FIFO wait cycles, then STAT_ADDR+4
    for (int i = 0; i < DEPTH; i++) wr(32'h300 + i);
    xfer(2'b10, 1'b1, DATA_ADDR, 3'b010, 32'h308, 2'b00, 32'd0, 5);
    step(4);
    pop(32'h300);
    step(2);
`ifdef L2_AHB_RX_SLV_WAITCNT_EN
    xfer(2'b10, 1'b0, STAT_ADDR + 32'd4, 3'b010, 32'h0, 2'b00, 32'd5, 0);
`else
    xfer(2'b10, 1'b0, STAT_ADDR + 32'd4, 3'b010, 32'h0, 2'b01, 32'd0, 1);
`endif
    step(3);

    // Three writes then status read
    pin_l2_clr = 1'b1;
    step(1);
    pin_l2_clr = 1'b0;
    wr(32'hA1); wr(32'hA2); wr(32'hA3);
    xfer(2'b10, 1'b0, STAT_ADDR, 3'b010, 32'h0, 2'b00, 32'h0000_000C, 0);
    step(2);
    pop(32'hA1);
    step(1);
    chk_stat("end", 4'd2, 1'b0, 1'b0);

    chk("exp_q_drained",  exp_q.size(),  32'd0);
    chk("dout_q_drained", dout_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

endmodule
